// File: rtl/weight_load_sched_pkg.sv
// rtl/weight_load_sched_pkg.sv - layer codes, phase-count defaults and scheduler state encoding
package weight_load_sched_pkg;

  localparam logic [3:0] LAYER0 = 4'd0;
  localparam logic [3:0] LAYER1 = 4'd1;
  localparam logic [3:0] LAYER2 = 4'd2;
  localparam logic [3:0] LAYER3 = 4'd3;
  localparam logic [3:0] AFFINE = 4'd4;

  localparam int DEF_NUM_PHASE    = 8;
  localparam int DEF_AFFINE_PHASE = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FILL  = 3'd2,
    S_CALC  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  function automatic logic cs_legal(input logic [3:0] cs);
    return (cs == LAYER0) || (cs == LAYER1) || (cs == LAYER2) ||
           (cs == LAYER3) || (cs == AFFINE);
  endfunction

endpackage

// File: rtl/weight_load_sched_phase_cnt.sv
// rtl/weight_load_sched_phase_cnt.sv - phase register with per-layer last-phase detect
module weight_load_sched_phase_cnt #(
  parameter int NUM_PHASE    = 8,
  parameter int AFFINE_PHASE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] cs,
  output logic [2:0] phase,
  output logic       last
);
  import weight_load_sched_pkg::*;

  logic [2:0] last_idx;

  assign last_idx = (cs == AFFINE) ? 3'(AFFINE_PHASE - 1) : 3'(NUM_PHASE - 1);
  assign last     = (phase == last_idx);

  // Saturates on the last phase so the index never wraps inside a layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= 3'd0;
    else if (clr)
      phase <= 3'd0;
    else if (inc && !last)
      phase <= phase + 3'd1;
  end

endmodule

// File: rtl/weight_load_sched.sv
// rtl/weight_load_sched.sv - steps one weight_store bank through every phase of a layer
module weight_load_sched #(
  parameter int NUM_PHASE    = 8,
  parameter int AFFINE_PHASE = 4,
  parameter int MASK_CYC     = 2,
  parameter int TIMEOUT      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cs_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] ws_cs,
  output logic [2:0] ws_phase,
  output logic       ws_load,
  input  logic       ws_valid,
  output logic       calc_start,
  input  logic       calc_done
);
  import weight_load_sched_pkg::*;

  localparam int MW = (MASK_CYC > 0) ? $clog2(MASK_CYC + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [MW-1:0] mask_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          accept, masking, phase_last;
  logic          busy_nxt, done_nxt, load_nxt, cstart_nxt;

  assign accept  = (state == S_IDLE) && start;
  assign masking = (mask_cnt < MW'(MASK_CYC));

  weight_load_sched_phase_cnt #(
    .NUM_PHASE    (NUM_PHASE),
    .AFFINE_PHASE (AFFINE_PHASE)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (state == S_NEXT),
    .cs    (ws_cs),
    .phase (ws_phase),
    .last  (phase_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = cs_legal(cs_in) ? S_SETUP : S_ERR;
      S_SETUP: state_nxt = S_FILL;
      S_FILL: begin
        // valid still reflects the previous phase until the store has re-read
        if (!masking) begin
          if (ws_valid)
            state_nxt = S_CALC;
          else if (tmo_cnt == TW'(TIMEOUT - 1))
            state_nxt = S_ERR;
        end
      end
      S_CALC:  if (!calc_start && calc_done) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = phase_last ? S_DONE : S_SETUP;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt   = state_nxt inside {S_SETUP, S_FILL, S_CALC, S_NEXT};
    load_nxt   = state_nxt inside {S_FILL, S_CALC, S_NEXT};
    done_nxt   = (state_nxt == S_DONE);
    cstart_nxt = (state == S_FILL) && (state_nxt == S_CALC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (state != S_FILL) begin
      mask_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (masking) begin
      mask_cnt <= mask_cnt + MW'(1);
    end else if (!ws_valid) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ws_load    <= 1'b0;
      calc_start <= 1'b0;
      ws_cs      <= 4'd0;
    end else begin
      busy       <= busy_nxt;
      done       <= done_nxt;
      ws_load    <= load_nxt;
      calc_start <= cstart_nxt;
      if (accept)
        ws_cs <= cs_in;
      if (state_nxt == S_ERR)
        err <= 1'b1;
      else if (accept)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_weight_load_sched.sv
// tb/tb_weight_load_sched.sv - randomized cycle-by-cycle check of weight_load_sched against a phase-timeline model
module tb_weight_load_sched;
  import weight_load_sched_pkg::*;

  localparam int NUM_PHASE    = 8;
  localparam int AFFINE_PHASE = 4;
  localparam int MASK_CYC     = 2;
  localparam int TIMEOUT      = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cs_in;
  logic       busy, done, err;
  logic [3:0] ws_cs;
  logic [2:0] ws_phase;
  logic       ws_load;
  logic       ws_valid;
  logic       calc_start;
  logic       calc_done;

  always #5 clk = ~clk;

  weight_load_sched #(
    .NUM_PHASE    (NUM_PHASE),
    .AFFINE_PHASE (AFFINE_PHASE),
    .MASK_CYC     (MASK_CYC),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cs_in      (cs_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ws_cs      (ws_cs),
    .ws_phase   (ws_phase),
    .ws_load    (ws_load),
    .ws_valid   (ws_valid),
    .calc_start (calc_start),
    .calc_done  (calc_done)
  );

  // One entry per clock: inputs driven during that cycle and outputs expected in it.
  typedef struct packed {
    logic       start;
    logic [3:0] cs_in;
    logic       valid;
    logic       cdone;
    logic       busy;
    logic       done;
    logic       err;
    logic       load;
    logic       cstart;
    logic [2:0] phase;
    logic [3:0] cs;
  } cyc_t;

  cyc_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         obs_cstart;
  int         obs_done;
  logic       m_err   = 1'b0;
  logic [2:0] m_phase = 3'd0;
  logic [3:0] m_cs    = 4'd0;

  function automatic logic ns(input bit noise);
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic logic [3:0] nc();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic st, input logic [3:0] ci, input logic v, input logic cd,
                      input logic b, input logic dn, input logic e, input logic ld,
                      input logic cst, input logic [2:0] ph, input logic [3:0] cs);
    cyc_t c;
    c.start = st;  c.cs_in = ci; c.valid = v;   c.cdone = cd;
    c.busy  = b;   c.done  = dn; c.err   = e;   c.load  = ld;
    c.cstart = cst; c.phase = ph; c.cs   = cs;
    q.push_back(c);
  endtask

  task automatic plan_idle(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, nc(), 1'b0, 1'b0, 1'b0, 1'b0, m_err, 1'b0, 1'b0, m_phase, m_cs);
  endtask

  task automatic plan_layer(input logic [3:0] code, input bit rnd, input bit stale,
                            input bit noise, input bit coinc);
    int nph, vlat, clat, sn;
    bit legal;
    legal = (code == LAYER0) || (code == LAYER1) || (code == LAYER2) ||
            (code == LAYER3) || (code == AFFINE);
    nph = (code == AFFINE) ? AFFINE_PHASE : NUM_PHASE;
    push(1'b1, code, 1'b0, 1'b0, 1'b0, 1'b0, m_err, 1'b0, 1'b0, m_phase, m_cs);
    if (!legal) begin
      push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, code);
      push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, code);
      m_err = 1'b1; m_phase = 3'd0; m_cs = code;
      return;
    end
    for (int p = 0; p < nph; p++) begin
      vlat = rnd ? int'($urandom_range(MASK_CYC, 9)) : 5;
      clat = rnd ? int'($urandom_range(1, 4)) : 1;
      sn   = stale ? int'($urandom_range(1, MASK_CYC)) : 0;
      push(ns(noise), nc(), 1'(stale), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'(p), code);
      for (int j = 0; j <= vlat; j++)
        push(ns(noise), nc(), (j < sn) || (j >= vlat), 1'b0,
             1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(p), code);
      for (int j = 0; j <= clat; j++)
        push(ns(noise), nc(), 1'b1, (j == clat) || (j == 0 && coinc),
             1'b1, 1'b0, 1'b0, 1'b1, (j == 0), 3'(p), code);
      push(ns(noise), nc(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(p), code);
    end
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'(nph - 1), code);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(nph - 1), code);
    m_err = 1'b0; m_phase = 3'(nph - 1); m_cs = code;
  endtask

  task automatic plan_timeout(input logic [3:0] code, input bit stale);
    int sn;
    sn = stale ? MASK_CYC : 0;
    push(1'b1, code, 1'b0, 1'b0, 1'b0, 1'b0, m_err, 1'b0, 1'b0, m_phase, m_cs);
    push(1'b0, 4'd0, 1'(stale), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, code);
    for (int j = 0; j < MASK_CYC + TIMEOUT; j++)
      push(1'b0, 4'd0, (j < sn), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, code);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, code);
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, code);
    m_err = 1'b1; m_phase = 3'd0; m_cs = code;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_q(input string tag);
    cyc_t c;
    int   k;
    k = 0;
    obs_cstart = 0;
    obs_done   = -1;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      start     = c.start;
      cs_in     = c.cs_in;
      ws_valid  = c.valid;
      calc_done = c.cdone;
      checks++;
      if ({busy, done, err, ws_load, calc_start, ws_phase, ws_cs} !==
          {c.busy, c.done, c.err, c.load, c.cstart, c.phase, c.cs}) begin
        errors++;
        $display("FAIL %s cyc%0d: got busy=%b done=%b err=%b load=%b cstart=%b phase=%0d cs=%h want busy=%b done=%b err=%b load=%b cstart=%b phase=%0d cs=%h",
                 tag, k, busy, done, err, ws_load, calc_start, ws_phase, ws_cs,
                 c.busy, c.done, c.err, c.load, c.cstart, c.phase, c.cs);
      end
      if (calc_start === 1'b1) obs_cstart++;
      if (done === 1'b1 && obs_done < 0) obs_done = k;
      k++;
    end
  endtask

  initial begin
    logic [3:0] code;
    int         r;
    rst = 1'b1; start = 1'b0; cs_in = 4'd0; ws_valid = 1'b0; calc_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy, done, err, ws_load, calc_start, ws_phase, ws_cs}), 0);
    rst = 1'b0;
    plan_idle(2);
    run_q("idle");

    plan_layer(LAYER1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("model_l1_len", q.size(), 83);
    chk("model_l1_done_at_81", int'(q[81].done), 1);
    run_q("layer1");
    chk("l1_calc_starts", obs_cstart, 8);
    chk("l1_done_cycle", obs_done, 81);

    plan_layer(AFFINE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("model_affine_len", q.size(), 43);
    run_q("affine");
    chk("affine_calc_starts", obs_cstart, 4);
    chk("affine_done_cycle", obs_done, 41);

    plan_layer(LAYER0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_q("stale_valid");

    plan_timeout(LAYER3, 1'b1);
    chk("model_tmo_len", q.size(), 38);
    chk("model_tmo_err_at_36", int'(q[36].err), 1);
    run_q("timeout");
    chk("tmo_no_done", obs_done, -1);
    chk("tmo_err_sticky", int'(err), 1);
    plan_idle(3);
    plan_layer(LAYER2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_q("after_timeout");

    plan_layer(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("model_illegal_len", q.size(), 3);
    plan_idle(2);
    run_q("illegal_cs");
    chk("illegal_no_calc", obs_cstart, 0);

    plan_layer(LAYER2, 1'b0, 1'b0, 1'b0, 1'b0);
    q = q[0:38];
    run_q("pre_reset");
    chk("rst_pre_phase", int'(ws_phase), 3);
    #2 rst = 1'b1;
    start = 1'b0; ws_valid = 1'b0; calc_done = 1'b0;
    #1 chk("rst_async_clear", int'({busy, done, err, ws_load, calc_start, ws_phase, ws_cs}), 0);
    @(negedge clk);
    rst = 1'b0;
    m_err = 1'b0; m_phase = 3'd0; m_cs = 4'd0;
    plan_idle(1);
    plan_layer(LAYER3, 1'b1, 1'b0, 1'b1, 1'b1);
    run_q("restart_noise_coinc");
    chk("restart_calc_starts", obs_cstart, 8);

    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 5));
      code = (r < 5) ? 4'(r) : 4'($urandom_range(5, 15));
      if (i == 3)
        plan_timeout(code < 5 ? code : LAYER0, 1'($urandom_range(0, 1)));
      else
        plan_layer(code, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      plan_idle(int'($urandom_range(0, 3)));
      run_q("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_load_sched.md
Name: weight_load_sched

Overview:
Sequencer that drives one weight_store bank (cs/phase/load/valid interface) through every phase of a selected layer.
- Per phase: programs cs/phase, pulses load low to re-initialise the store, then raises load and waits for valid.
- Then hands the 36-word weight vector to the compute engine through a start/done handshake and advances phase.
- Sits between the top-level layer FSM and the weight_store_* instances.

Parameters:
NUM_PHASE, 8, phases per conv layer (LAYER0..LAYER3); range 1..8
AFFINE_PHASE, 4, phases for the AFFINE layer; range 1..8
MASK_CYC, 2, cycles after load rise during which ws_valid is ignored (valid is stale from the previous phase)
TIMEOUT, 32, max cycles in FILL before err; counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock; all flops rise-edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to run a layer; sampled only in IDLE
cs_in  in  4  layer code (`LAYER0..`LAYER3, `AFFINE); captured with start
busy  out  1  high from the cycle after start until done/err
done  out  1  one-cycle pulse when the last phase's calc_done is received
err  out  1  sticky error flag; cleared by the next accepted start or by rst
ws_cs  out  4  cs to weight store; registered, stable whenever ws_load=1
ws_phase  out  3  phase to weight store; registered
ws_load  out  1  load to weight store
ws_valid  in  1  valid from weight store
calc_start  out  1  one-cycle pulse: weights on weight-store q are ready
calc_done  in  1  compute engine finished with current weights

Behaviour:
- Reset (async, rst=1): state=IDLE; ws_load=0, ws_cs=0, ws_phase=0, calc_start=0, busy=0, done=0, err=0; counters 0. Reset mid-run abandons the layer with no done pulse.
- States: IDLE, SETUP, FILL, CALC, NEXT, DONE, ERR.
- IDLE: on start=1, capture cs_in into ws_cs; ws_phase=0; clear err; busy=1.
  - If cs_in is not a legal code, go to ERR; otherwise go to SETUP.
  - start while busy is ignored.
- SETUP (exactly 1 cycle): ws_load=0, so the store re-inits and latches offset from the stable cs/phase. Go to FILL.
- FILL: ws_load=1; mask_cnt counts 0..MASK_CYC-1 and ws_valid is ignored while masking.
  - After the mask, ws_valid=1 leads to CALC and asserts calc_start for exactly the entry cycle.
  - Nominal: valid appears on the 6th edge after ws_load rises, so FILL lasts 6 cycles.
  - tmo_cnt reaching TIMEOUT without valid leads to ERR.
- CALC: ws_load stays 1 so q holds. calc_done is sampled from the cycle after calc_start; calc_done coincident with calc_start is ignored. calc_done=1 leads to NEXT.
- NEXT (1 cycle): last = (ws_phase == P-1), where P = AFFINE_PHASE if ws_cs==`AFFINE, else NUM_PHASE.
  - If last: go to DONE.
  - Else: ws_phase <= ws_phase+1 and go to SETUP.
  - ws_phase never wraps within a layer.
- DONE: done=1 for one cycle, busy=0, ws_load=0; then IDLE.
- ERR: ws_load=0, busy=0, err=1 held; go to IDLE next cycle; err stays set until the next accepted start.
- Outputs are registered (Moore); no combinational path from ws_valid/calc_done to outputs.
- Per-phase latency, nominal store, zero-wait compute: SETUP 1 + FILL 6 + CALC 2 + NEXT 1 = 10 cycles.

Decomposition:
- Layer codes `LAYER0..`AFFINE and `data_len come from the shared state_layer_data.v / num_data.v includes.
- Add to the shared include: phase-count constants and the scheduler state encoding (3 bits).
- Optional sub-module: wls_phase_cnt (phase register, last-phase compare, P select).

Test Plan:
- LAYER1, store model with valid at 6 edges, calc_done 1 cycle after calc_start -> 8 calc_start pulses with ws_phase 0..7, ws_cs=`LAYER1, ws_load low exactly 1 cycle before each phase, done at ~cycle 81 after start.
- AFFINE -> 4 phases only (ws_phase 0..3), done pulse, busy low the cycle after done.
- Stale valid held high from the previous phase -> no calc_start during the first MASK_CYC FILL cycles.
- Store never asserts valid -> err=1 after 2+32 cycles; ws_load=0, busy=0, no done; next start clears err.
- Illegal cs_in=4'hF with start -> err next cycle, ws_load never rises.
- rst asserted in CALC of phase 3 -> all outputs 0 asynchronously; new start after release restarts at phase 0.
- start pulsed during busy, and calc_done coincident with calc_start -> both ignored; sequence unchanged.
